imm_gen_fifo: RTL
=================

// Module: imm_gen_fifo
// PURPOSE
//  Buffered immediate generator for the EXU front: accepts raw RV32I instruction words over a
//  valid/ready handshake and classifies each one by format (I/S/B/U/J, opt. CSR zimm).
//  Builds the XLEN sign-extended immediate and queues the result, with a tag, in a DEPTH-entry FIFO.
//  Decouples decode from issue; replaces the per-format combinational imm decoders at the EXU boundary.
// PARAMETERS
//  XLEN    32  immediate output width (32 or 64); sign extension fills bits XLEN-1..msb
//  DEPTH   2   FIFO entries (>=1, need not be power of 2)
//  TAG_W   4   width of opaque sideband tag carried with each instruction
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst         in   1       synchronous reset, active-high
//  flush       in   1       synchronous clear of all queued entries
//  in_vld      in   1       instruction word valid
//  in_rdy      out  1       block can accept (registered, = !full)
//  in_inst     in   32      raw instruction word (rv32i_inst_t layout)
//  in_tag      in   TAG_W   sideband tag, returned unchanged
//  out_vld     out  1       head entry valid (= !empty)
//  out_rdy     in   1       consumer accepts head
//  out_imm     out  XLEN    generated immediate
//  out_fmt     out  3       0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z(zimm),7 reserved
//  out_illegal out  1       opcode unrecognised or inst[1:0]!=2'b11
//  out_tag     out  TAG_W   tag of head entry
// BEHAVIOUR
//  - Push when in_vld&in_rdy; pop when out_vld&out_rdy. Latency 1: pushed in cycle N, visible N+1.
//  - in_rdy depends only on registered count: no comb path out_rdy->in_rdy. Full+pop: in_rdy stays 0
//    that cycle, rises next cycle. Empty+push: out_vld rises next cycle (no bypass).
//  - Decode by opcode inst[6:0]: 0000011/0010011/1100111 -> I; 0100011 -> S; 1100011 -> B;
//    0110111/0010111 -> U; 1101111 -> J; 1110011 -> I (see CONFIG); 0110011/0001111 -> NONE, imm 0.
//    Other opcodes, or inst[1:0]!=2'b11 -> NONE, imm 0, out_illegal=1.
//  - Imm: I {sx,inst[31:20]}; S {sx,inst[31:25],inst[11:7]}; B {sx,inst[31],inst[7],inst[30:25],
//    inst[11:8],0}; U {sx,inst[31:12],12'b0}; J {sx,inst[31],inst[19:12],inst[20],inst[30:21],0}.
//    sx = replicate inst[31] up to XLEN (U also sign-extends for XLEN=64).
//  - Decode is combinational on in_inst; only decoded fields (imm,fmt,illegal,tag) are stored.
//  - Pointers wrap DEPTH-1 -> 0; count 0..DEPTH; simultaneous push+pop leaves count unchanged.
//  - flush: next cycle count=0, pointers=0, out_vld=0, in_rdy=1; push/pop in same cycle are dropped.
//  - Reset (priority over flush): count/pointers 0, out_vld 0, in_rdy 1, out_imm/fmt/illegal/tag 0.
//  - When empty out_imm/out_fmt/out_illegal/out_tag are driven 0 (no stale head data).
// CONFIGURATION
//  IMM_GEN_ZIMM_EN defined: opcode 1110011 with funct3 in {101,110,111} -> fmt Z,
//    imm = zero-extended inst[19:15]; other SYSTEM funct3 -> I.
//  Not defined: all SYSTEM instructions -> I; fmt 6 never produced.
// TESTING
//  T1 push 0xFFF00093 (addi -1), out_rdy=1 -> next cycle out_vld=1, fmt I, imm 0xFFFFFFFF.
//  T2 push 0xFE112E23, 0xFE000CE3, 0x123450B7, 0x0010006F back-to-back -> S 0xFFFFFFFC,
//     B 0xFFFFFFF8, U 0x12345000, J 0x00000800 in order, tags preserved, no bubbles.
//  T3 DEPTH=2, out_rdy=0, push 3 words -> in_rdy=0 after 2nd; raise out_rdy -> in_rdy returns
//     one cycle after first pop, 3rd word delivered last, order intact.
//  T4 push 0x3002D073: ZIMM_EN -> fmt 6, imm 0x00000005; without -> fmt 1, imm 0x00000300.
//  T5 push 0x00000000 and 0x0000007F -> fmt 0, imm 0, out_illegal=1; 0x00B50533 (add) -> illegal=0.
//  T6 2 entries queued, assert flush with in_vld=1 -> next cycle out_vld=0, count 0, word dropped;
//     assert rst mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/imm_gen_fifo.sv
// Buffered RV32I immediate generator: decode on entry, queue imm/fmt/illegal/tag in a small FIFO.
// Optional build macro IMM_GEN_ZIMM_EN: SYSTEM funct3 101/110/111 yield fmt Z with zero-extended zimm.
module imm_gen_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_I    = 3'd1;
    localparam logic [2:0] F_S    = 3'd2;
    localparam logic [2:0] F_B    = 3'd3;
    localparam logic [2:0] F_U    = 3'd4;
    localparam logic [2:0] F_J    = 3'd5;
    localparam logic [2:0] F_Z    = 3'd6;

    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_fmt = F_NONE;
        dec_ill = 1'b0;
        case (in_inst[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111: dec_fmt = F_I;
            7'b0100011: dec_fmt = F_S;
            7'b1100011: dec_fmt = F_B;
            7'b0110111,
            7'b0010111: dec_fmt = F_U;
            7'b1101111: dec_fmt = F_J;
            7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
                if (in_inst[14] && (in_inst[13:12] != 2'b00))
                    dec_fmt = F_Z;
                else
                    dec_fmt = F_I;
`else
                dec_fmt = F_I;
`endif
            end
            7'b0110011,
            7'b0001111: dec_fmt = F_NONE;
            default:    dec_ill = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            dec_fmt = F_NONE;
            dec_ill = 1'b1;
        end
    end

    always_comb begin
        dec_imm = '0;
        case (dec_fmt)
            F_I: dec_imm = XLEN'($signed(in_inst[31:20]));
            F_S: dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            F_B: dec_imm = XLEN'($signed({in_inst[31], in_inst[7],
                                          in_inst[30:25], in_inst[11:8], 1'b0}));
            F_U: dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            F_J: dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12],
                                          in_inst[20], in_inst[30:21], 1'b0}));
            F_Z: dec_imm = XLEN'(in_inst[19:15]);
            default: dec_imm = '0;
        endcase
    end

    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [2:0]       fmt_q [DEPTH];
    logic             ill_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt, cnt_n;
    logic          rdy_q, vld_q;
    logic          push, pop;

    assign push = in_vld && rdy_q;
    assign pop  = vld_q && out_rdy;

    always_comb begin
        cnt_n = cnt;
        case ({push, pop})
            2'b10:   cnt_n = cnt + CW'(1);
            2'b01:   cnt_n = cnt - CW'(1);
            default: cnt_n = cnt;
        endcase
    end

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop)  rptr <= inc(rptr);
            cnt   <= cnt_n;
            rdy_q <= (cnt_n != CW'(DEPTH));
            vld_q <= (cnt_n != '0);
        end
    end

    // Payload needs no reset: it is only observed through the valid gate below.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            imm_q[wptr] <= dec_imm;
            fmt_q[wptr] <= dec_fmt;
            ill_q[wptr] <= dec_ill;
            tag_q[wptr] <= in_tag;
        end
    end

    assign in_rdy      = rdy_q;
    assign out_vld     = vld_q;
    assign out_imm     = vld_q ? imm_q[rptr] : '0;
    assign out_fmt     = vld_q ? fmt_q[rptr] : '0;
    assign out_illegal = vld_q ? ill_q[rptr] : 1'b0;
    assign out_tag     = vld_q ? tag_q[rptr] : '0;

endmodule
